// File: rtl/countdown_pkg.sv
// Shared definitions for the BCD countdown timer: state encoding, digit limits
// and the nibble layout of the preset word.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam logic [3:0] DIGIT_MAX = 4'd9;
    localparam logic [3:0] TENS_MAX  = 4'd5;

    localparam int NIB_CENTISEC = 0;
    localparam int NIB_DECISEC  = 1;
    localparam int NIB_SEC      = 2;
    localparam int NIB_DECASEC  = 3;
    localparam int NIB_MIN      = 4;
    localparam int NIB_DECAMIN  = 5;
    localparam int NIB_HR       = 6;
    localparam int NIB_DECAHR   = 7;
    localparam int NUM_DIGITS   = 8;

    // Tens-of-seconds and tens-of-minutes run 0..5; every other digit runs 0..9.
    function automatic logic [3:0] digit_max(input int idx);
        return (idx == NIB_DECASEC || idx == NIB_DECAMIN) ? TENS_MAX : DIGIT_MAX;
    endfunction

    function automatic logic preset_legal(input logic [31:0] preset);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (preset[i*4 +: 4] > digit_max(i)) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the countdown chain; decrements when the chain borrows into it
// and wraps to MAX when it borrows out.
module bcd_down_digit
    import countdown_pkg::*;
#(
    parameter logic [3:0] MAX = DIGIT_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dec,
    input  logic       borrow_in,
    input  logic       load,
    input  logic       clear,
    input  logic [3:0] load_value,
    output logic [3:0] value,
    output logic       borrow_out,
    output logic       is_zero
);

    assign is_zero    = (value == 4'd0);
    assign borrow_out = borrow_in && is_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= 4'd0;
        end else if (clear) begin
            value <= 4'd0;
        end else if (load) begin
            value <= load_value;
        end else if (dec && borrow_in) begin
            value <= is_zero ? MAX : value - 4'd1;
        end
    end

endmodule

// File: rtl/countdown_timer_module.sv
// BCD countdown timer: button edge detection, clear/load/run priority, run-state
// FSM and centisecond prescaler driving an eight-digit borrow chain.
module countdown_timer_module
    import countdown_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        run_pause_button_i,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [31:0] set_time_i,
    output logic [3:0]  centisec_o,
    output logic [3:0]  decisec_o,
    output logic [3:0]  sec_o,
    output logic [3:0]  decasec_o,
    output logic [3:0]  min_o,
    output logic [3:0]  decamin_o,
    output logic [3:0]  hr_o,
    output logic [3:0]  decahr_o,
    output logic        running_o,
    output logic        expired_o,
    output logic        load_error_o
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_t              state;
    logic [PW-1:0]       presc;
    logic                run_prev;
    logic                load_prev;
    logic                clear_prev;
    logic                run_edge;
    logic                load_edge;
    logic                clear_edge;
    logic                preset_ok;
    logic                tick;
    logic                dec;
    logic                digit_load;
    logic                count_zero;
    logic                count_one;
    logic [7:0][3:0]     digits;
    logic [7:0]          is_zero;
    logic [8:0]          borrow;

    assign run_edge   = run_pause_button_i && !run_prev;
    assign load_edge  = load_i && !load_prev;
    assign clear_edge = clear_i && !clear_prev;
    assign preset_ok  = preset_legal(set_time_i);

    assign tick       = (state == RUNNING) && (presc == PRESC_LAST);
    // A clear or load edge takes the whole cycle; the tick that coincides is dropped.
    assign dec        = tick && !clear_edge && !load_edge;
    assign digit_load = load_edge && !clear_edge && preset_ok;

    // Borrow out of the top digit means every digit is zero.
    assign count_zero = borrow[8];
    assign count_one  = (is_zero[7:1] == 7'h7f) && !is_zero[0] && (digits[0][3:1] == 3'd0);

    assign borrow[0] = 1'b1;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_down_digit #(
            .MAX(digit_max(i))
        ) u_digit (
            .clk       (clk_i),
            .rst       (reset_i),
            .dec       (dec),
            .borrow_in (borrow[i]),
            .load      (digit_load),
            .clear     (clear_edge),
            .load_value(set_time_i[i*4 +: 4]),
            .value     (digits[i]),
            .borrow_out(borrow[i+1]),
            .is_zero   (is_zero[i])
        );
    end

    assign centisec_o = digits[NIB_CENTISEC];
    assign decisec_o  = digits[NIB_DECISEC];
    assign sec_o      = digits[NIB_SEC];
    assign decasec_o  = digits[NIB_DECASEC];
    assign min_o      = digits[NIB_MIN];
    assign decamin_o  = digits[NIB_DECAMIN];
    assign hr_o       = digits[NIB_HR];
    assign decahr_o   = digits[NIB_DECAHR];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            run_prev   <= 1'b0;
            load_prev  <= 1'b0;
            clear_prev <= 1'b0;
        end else begin
            run_prev   <= run_pause_button_i;
            load_prev  <= load_i;
            clear_prev <= clear_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state        <= IDLE;
            presc        <= '0;
            running_o    <= 1'b0;
            expired_o    <= 1'b0;
            load_error_o <= 1'b0;
        end else begin
            load_error_o <= 1'b0;
            if (clear_edge) begin
                state     <= IDLE;
                presc     <= '0;
                running_o <= 1'b0;
                expired_o <= 1'b0;
            end else if (load_edge) begin
                if (preset_ok) begin
                    state     <= IDLE;
                    presc     <= '0;
                    running_o <= 1'b0;
                    expired_o <= 1'b0;
                end else begin
                    load_error_o <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (run_edge && !count_zero) begin
                            state     <= RUNNING;
                            running_o <= 1'b1;
                        end
                    end
                    RUNNING: begin
                        presc <= tick ? '0 : presc + 1'b1;
                        // Reaching zero outranks a simultaneous pause so PAUSED never holds a zero count.
                        if (tick && count_one) begin
                            state     <= EXPIRED;
                            running_o <= 1'b0;
                            expired_o <= 1'b1;
                        end else if (run_edge) begin
                            state     <= PAUSED;
                            running_o <= 1'b0;
                        end
                    end
                    PAUSED: begin
                        if (run_edge) begin
                            state     <= RUNNING;
                            running_o <= 1'b1;
                        end
                    end
                    EXPIRED: begin
                    end
                    default: begin
                        state     <= IDLE;
                        running_o <= 1'b0;
                        expired_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
